fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that feeds pipe_if_dec.
- Owns the fetch PC and drives the icache request and refill handshake.
- Generates the IF/DEC latch controls: stall, flush and the imembubble qualifier.
- Handles branch redirects, including redirects that arrive while an icache miss is outstanding.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/sat_counter.sv | 20 ++
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// default fetch granularity and the PC alignment helper.
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MISS_REQ  = 2'd1,
      MISS_WAIT = 2'd2
   } fetch_state_e;

   localparam int unsigned DEFAULT_INST_BYTES = 4;

   // Mask that clears the byte-offset bits of an instruction address;
   // inst_bytes is expected to be a power of two.
   function automatic logic [63:0] align_mask(input int unsigned inst_bytes);
      return ~(64'(inst_bytes) - 64'd1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_Clk,
   input  logic             i_Reset_n,
   input  logic             i_Inc,
   output logic [WIDTH-1:0] o_Count
);

   // NOTE: state registers take non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n)
         o_Count <= '0;
      else if (i_Inc && (o_Count != '1))
         o_Count <= o_Count + WIDTH'(1);
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the icache miss/refill
// handshake and produces the IF/DEC latch stall, flush and bubble controls.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned                  ADDRESS_WIDTH  = 32,
   parameter logic [ADDRESS_WIDTH-1:0]     RESET_PC       = '0,
   parameter int unsigned                  INST_BYTES     = DEFAULT_INST_BYTES,
   parameter int unsigned                  MISS_CNT_WIDTH = 16
) (
   input  logic                      i_Clk,
   input  logic                      i_Reset_n,
   input  logic                      i_Stall,
   input  logic                      i_BranchTaken,
   input  logic [ADDRESS_WIDTH-1:0]  i_BranchTarget,
   input  logic                      i_ICacheHit,
   input  logic                      i_ICacheRefillDone,
   output logic [ADDRESS_WIDTH-1:0]  o_FetchPC,
   output logic                      o_ICacheReq,
   output logic                      o_ICacheMissReq,
   output logic                      o_IFDEC_Stall,
   output logic                      o_IFDEC_Flush,
   output logic                      o_imembubble,
   output logic [MISS_CNT_WIDTH-1:0] o_MissCount
);

   localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(align_mask(INST_BYTES));
   localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(INST_BYTES);

   fetch_state_e             state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] pc, pc_nxt;
   logic                     pend_vld, pend_vld_nxt;
   logic [ADDRESS_WIDTH-1:0] pend_tgt, pend_tgt_nxt;
   logic [ADDRESS_WIDTH-1:0] branch_tgt;
   logic                     miss_inc;

   assign branch_tgt = i_BranchTarget & ALIGN_MASK;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state    <= RUN;
         pc       <= RESET_PC;
         pend_vld <= 1'b0;
         pend_tgt <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         pend_vld <= pend_vld_nxt;
         pend_tgt <= pend_tgt_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      pend_vld_nxt    = pend_vld;
      pend_tgt_nxt    = pend_tgt;
      o_ICacheReq     = 1'b0;
      o_ICacheMissReq = 1'b0;
      miss_inc        = 1'b0;

      unique case (state)
         RUN: begin
            o_ICacheReq = 1'b1;
            // A redirect wins over both a miss and a stall on the current PC.
            if (i_BranchTaken) begin
               pc_nxt = branch_tgt;
            end else if (!i_ICacheHit) begin
               state_nxt = MISS_REQ;
               miss_inc  = 1'b1;
            end else if (!i_Stall) begin
               pc_nxt = pc + PC_STEP;
            end
         end

         MISS_REQ: begin
            o_ICacheMissReq = 1'b1;
            state_nxt       = MISS_WAIT;
            if (i_BranchTaken) begin
               pend_vld_nxt = 1'b1;
               pend_tgt_nxt = branch_tgt;
            end
         end

         MISS_WAIT: begin
            // The refill always completes; a redirect seen meanwhile is parked.
            if (i_ICacheRefillDone) begin
               state_nxt    = RUN;
               pend_vld_nxt = 1'b0;
               if (i_BranchTaken)
                  pc_nxt = branch_tgt;
               else if (pend_vld)
                  pc_nxt = pend_tgt;
            end else if (i_BranchTaken) begin
               pend_vld_nxt = 1'b1;
               pend_tgt_nxt = branch_tgt;
            end
         end

         default: begin
            state_nxt    = RUN;
            pend_vld_nxt = 1'b0;
         end
      endcase
   end

   sat_counter #(
      .WIDTH (MISS_CNT_WIDTH)
   ) u_miss_cnt (
      .i_Clk     (i_Clk),
      .i_Reset_n (i_Reset_n),
      .i_Inc     (miss_inc),
      .o_Count   (o_MissCount)
   );

   assign o_FetchPC     = pc;
   assign o_imembubble  = (state != RUN) | ~i_ICacheHit;
   assign o_IFDEC_Flush = i_BranchTaken;
   // The latch favours stall over flush, so a redirect must drop the stall.
   assign o_IFDEC_Stall = i_Stall & ~i_BranchTaken;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; a narrow-counter twin shares all inputs so
// miss-count saturation is reachable in a short run.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        br;
   logic [31:0] tgt;
   logic        hit;
   logic        refill;

   logic [31:0] pc;
   logic        req, miss_req, ifdec_stall, ifdec_flush, bubble;
   logic [15:0] miss_cnt;

   logic [31:0] pc_s;
   logic        req_s, miss_req_s, ifdec_stall_s, ifdec_flush_s, bubble_s;
   logic [3:0]  miss_cnt_s;

   int checks = 0;
   int errors = 0;

   fetch_ctrl dut (
      .i_Clk              (clk),
      .i_Reset_n          (rst_n),
      .i_Stall            (stall),
      .i_BranchTaken      (br),
      .i_BranchTarget     (tgt),
      .i_ICacheHit        (hit),
      .i_ICacheRefillDone (refill),
      .o_FetchPC          (pc),
      .o_ICacheReq        (req),
      .o_ICacheMissReq    (miss_req),
      .o_IFDEC_Stall      (ifdec_stall),
      .o_IFDEC_Flush      (ifdec_flush),
      .o_imembubble       (bubble),
      .o_MissCount        (miss_cnt)
   );

   fetch_ctrl #(.MISS_CNT_WIDTH(4)) dut_small (
      .i_Clk              (clk),
      .i_Reset_n          (rst_n),
      .i_Stall            (stall),
      .i_BranchTaken      (br),
      .i_BranchTarget     (tgt),
      .i_ICacheHit        (hit),
      .i_ICacheRefillDone (refill),
      .o_FetchPC          (pc_s),
      .o_ICacheReq        (req_s),
      .o_ICacheMissReq    (miss_req_s),
      .o_IFDEC_Stall      (ifdec_stall_s),
      .o_IFDEC_Flush      (ifdec_flush_s),
      .o_imembubble       (bubble_s),
      .o_MissCount        (miss_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Step past the next rising edge; inputs then change well clear of it.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n  = 1'b0;
      stall  = 1'b0;
      br     = 1'b0;
      tgt    = '0;
      hit    = 1'b1;
      refill = 1'b0;

      #3;
      check("rst_pc",      pc,       32'h0);
      check("rst_req",     req,      32'h1);
      check("rst_missreq", miss_req, 32'h0);
      check("rst_cnt",     miss_cnt, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;

      // 1: sequential hits
      check("t1_pc0",     pc,          32'h0);
      check("t1_bubble",  bubble,      32'h0);
      check("t1_flush",   ifdec_flush, 32'h0);
      check("t1_stall",   ifdec_stall, 32'h0);
      cyc(); check("t1_pc4", pc, 32'h4);
      cyc(); check("t1_pc8", pc, 32'h8);
      cyc(); check("t1_pcC", pc, 32'hC);
      cyc(); check("t1_pc10", pc, 32'h10);

      // 2: single miss, refill three cycles after MISS_REQ
      hit = 1'b0; #1;
      check("t2_bub_run", bubble, 32'h1);
      check("t2_req_run", req,    32'h1);
      cyc(); hit = 1'b1; #1;
      check("t2_missreq", miss_req, 32'h1);
      check("t2_req_mr",  req,      32'h0);
      check("t2_bub_mr",  bubble,   32'h1);
      check("t2_cnt",     miss_cnt, 32'h1);
      cyc();
      check("t2_missreq_w", miss_req, 32'h0);
      check("t2_req_w",     req,      32'h0);
      check("t2_bub_w1",    bubble,   32'h1);
      cyc();
      check("t2_bub_w2", bubble, 32'h1);
      cyc(); refill = 1'b1; #1;
      check("t2_bub_w3", bubble, 32'h1);
      check("t2_pc_w3",  pc,     32'h10);
      cyc(); refill = 1'b0; #1;
      check("t2_pc_retry",  pc,     32'h10);
      check("t2_bub_retry", bubble, 32'h0);
      check("t2_req_retry", req,    32'h1);
      cyc();
      check("t2_pc14", pc,       32'h14);
      check("t2_cnt1", miss_cnt, 32'h1);

      // 3: redirect overrides stall in RUN, target aligned
      stall = 1'b1; br = 1'b1; tgt = 32'h203; #1;
      check("t3_ifdec_stall", ifdec_stall, 32'h0);
      check("t3_flush",       ifdec_flush, 32'h1);
      cyc(); br = 1'b0; #1;
      check("t3_pc200",     pc,          32'h200);
      check("t3_stall_only", ifdec_stall, 32'h1);
      check("t3_noflush",    ifdec_flush, 32'h0);
      cyc(); stall = 1'b0; #1;
      check("t3_pc_held", pc, 32'h200);
      cyc();
      check("t3_pc204", pc, 32'h204);

      // 4: two redirects during MISS_WAIT, last one wins
      hit = 1'b0;
      cyc(); hit = 1'b1;
      check("t4_cnt2", miss_cnt, 32'h2);
      cyc(); br = 1'b1; tgt = 32'h400; #1;
      check("t4_flush1", ifdec_flush, 32'h1);
      check("t4_pc_w",   pc,          32'h204);
      cyc(); br = 1'b0;
      cyc(); br = 1'b1; tgt = 32'h500; #1;
      check("t4_flush2", ifdec_flush, 32'h1);
      cyc(); br = 1'b0; refill = 1'b1; #1;
      check("t4_pc_still", pc, 32'h204);
      cyc(); refill = 1'b0; #1;
      check("t4_pc500",  pc,  32'h500);
      check("t4_req_run", req, 32'h1);
      cyc();
      check("t4_pc504", pc, 32'h504);
      // pending must be gone: a plain miss returns to the same PC
      hit = 1'b0;
      cyc(); hit = 1'b1;
      cyc(); refill = 1'b1;
      cyc(); refill = 1'b0; #1;
      check("t4_pend_clr", pc,       32'h504);
      check("t4_cnt3",     miss_cnt, 32'h3);
      // redirect captured in MISS_REQ, then a new one coinciding with refill
      hit = 1'b0;
      cyc(); hit = 1'b1; br = 1'b1; tgt = 32'h600;
      cyc(); tgt = 32'h700; refill = 1'b1;
      cyc(); br = 1'b0; refill = 1'b0; #1;
      check("t4_pc700", pc,       32'h700);
      check("t4_cnt4",  miss_cnt, 32'h4);
      // miss alongside a redirect in RUN is ignored
      hit = 1'b0; br = 1'b1; tgt = 32'h800;
      cyc(); hit = 1'b1; br = 1'b0; #1;
      check("t4_pc800",     pc,       32'h800);
      check("t4_no_missreq", miss_req, 32'h0);
      check("t4_no_cnt",    miss_cnt, 32'h4);
      check("t4_bub_run",   bubble,   32'h0);

      // 5: PC wrap and counter saturation
      br = 1'b1; tgt = 32'hFFFF_FFFF;
      cyc(); br = 1'b0; #1;
      check("t5_pc_top", pc, 32'hFFFF_FFFC);
      cyc();
      check("t5_pc_wrap", pc, 32'h0);
      for (int i = 0; i < 20; i++) begin
         hit = 1'b0;
         cyc(); hit = 1'b1;
         cyc(); refill = 1'b1;
         cyc(); refill = 1'b0;
      end
      #1;
      check("t5_cnt24",   miss_cnt,   32'h18);
      check("t5_sat",     miss_cnt_s, 32'hF);
      check("t5_pc_loop", pc,         32'h0);
      cyc();
      cyc();
      check("t5_pc8", pc, 32'h8);

      // 6: reset during MISS_WAIT, then a stray refill pulse
      hit = 1'b0;
      cyc(); hit = 1'b1;
      cyc();
      check("t6_in_wait", req, 32'h0);
      rst_n = 1'b0; #1;
      check("t6_rst_pc",  pc,       32'h0);
      check("t6_rst_req", req,      32'h1);
      check("t6_rst_cnt", miss_cnt, 32'h0);
      check("t6_rst_bub", bubble,   32'h0);
      cyc(); rst_n = 1'b1; stall = 1'b1; refill = 1'b1;
      cyc(); refill = 1'b0; #1;
      check("t6_stray_pc",  pc,       32'h0);
      check("t6_stray_req", req,      32'h1);
      check("t6_stray_mr",  miss_req, 32'h0);
      check("t6_stray_cnt", miss_cnt, 32'h0);
      stall = 1'b0;
      cyc();
      check("t6_run_pc4", pc, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
